reorder_buffer: RTL and testbench

- 16-entry circular reorder buffer that schedules in-order retirement into the register file.
- Allocates an entry per decoded instruction and drives the register file's rename update (update_valid/update_ROB_pos/update_rd).
- Captures results from the CDB and issues at most one in-order commit per cycle (commit_valid/commit_ROB_pos/commit_rd/commit_val).
- Raises a one-cycle flush on a mispredicted branch at retirement.

---
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 tb/tb_reorder_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates entries on issue, captures
// CDB results, retires in order one entry per cycle and raises a one-cycle
// flush when a mispredicted branch retires.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int POS_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_is_branch,
    output logic [POS_W-1:0] issue_ROB_pos,
    output logic             rob_full,
    output logic             update_valid,
    output logic [POS_W-1:0] update_ROB_pos,
    output logic [4:0]       update_rd,
    input  logic             cdb_valid,
    input  logic [POS_W-1:0] cdb_ROB_pos,
    input  logic [31:0]      cdb_val,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target_pc,
    input  logic [POS_W-1:0] query_pos1,
    input  logic [POS_W-1:0] query_pos2,
    output logic             query_ready1,
    output logic             query_ready2,
    output logic [31:0]      query_val1,
    output logic [31:0]      query_val2,
    output logic             commit_valid,
    output logic [POS_W-1:0] commit_ROB_pos,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic             rob_clear,
    output logic [31:0]      clear_pc
);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] is_branch;
    logic [ROB_SIZE-1:0] mispredict;
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [31:0]         val_q    [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];

    logic [POS_W-1:0] head;
    logic [POS_W-1:0] tail;
    logic [POS_W:0]   count;

    logic issue_accept;
    logic commit_fire;
    logic flush_fire;
    logic cdb_take;

    assign rob_full       = (count == (POS_W+1)'(ROB_SIZE));
    assign issue_accept   = issue_valid & ~rob_full & rdy & ~rst & ~rob_clear;
    assign commit_fire    = rdy & ~rst & ~rob_clear & (count != '0) & busy[head] & ready[head];
    assign flush_fire     = commit_fire & mispredict[head];
    assign cdb_take       = cdb_valid & ~rob_clear & busy[cdb_ROB_pos];

    assign issue_ROB_pos  = tail;
    assign update_valid   = issue_accept;
    assign update_ROB_pos = tail;
    assign update_rd      = issue_rd;

    // Operand forwarding: a result on the CDB this cycle beats the stored copy
    always_comb begin
        query_ready1 = ready[query_pos1];
        query_val1   = val_q[query_pos1];
        query_ready2 = ready[query_pos2];
        query_val2   = val_q[query_pos2];
        if (cdb_valid && (cdb_ROB_pos == query_pos1)) begin
            query_ready1 = 1'b1;
            query_val1   = cdb_val;
        end
        if (cdb_valid && (cdb_ROB_pos == query_pos2)) begin
            query_ready2 = 1'b1;
            query_val2   = cdb_val;
        end
    end

    // Entry state, pointers and registered retire/flush outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= '0;
            ready          <= '0;
            is_branch      <= '0;
            mispredict     <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_valid   <= 1'b0;
            commit_ROB_pos <= '0;
            commit_rd      <= '0;
            commit_val     <= '0;
            rob_clear      <= 1'b0;
            clear_pc       <= '0;
        end else if (rdy) begin
            commit_valid <= commit_fire;
            rob_clear    <= flush_fire;
            if (commit_fire) begin
                commit_ROB_pos <= head;
                commit_rd      <= rd_q[head];
                commit_val     <= val_q[head];
            end
            if (flush_fire) begin
                // Flush discards everything, including any same-cycle issue or CDB write
                clear_pc   <= target_q[head];
                busy       <= '0;
                ready      <= '0;
                mispredict <= '0;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
            end else begin
                if (cdb_take) begin
                    ready[cdb_ROB_pos]      <= 1'b1;
                    val_q[cdb_ROB_pos]      <= cdb_val;
                    mispredict[cdb_ROB_pos] <= cdb_mispredict & is_branch[cdb_ROB_pos];
                    target_q[cdb_ROB_pos]   <= cdb_target_pc;
                end
                // Issue is written after the CDB so it wins on a shared position
                if (issue_accept) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    is_branch[tail]  <= issue_is_branch;
                    mispredict[tail] <= 1'b0;
                    rd_q[tail]       <= issue_rd;
                    tail             <= tail + POS_W'(1);
                end
                if (commit_fire) begin
                    busy[head] <= 1'b0;
                    head       <= head + POS_W'(1);
                end
                unique case ({issue_accept, commit_fire})
                    2'b10:   count <= count + (POS_W+1)'(1);
                    2'b01:   count <= count - (POS_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based ROB model predicts
// combinational outputs and the retire stream; a monitor checks commits.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_is_branch = 1'b0;
    logic [3:0]  issue_ROB_pos;
    logic        rob_full;
    logic        update_valid;
    logic [3:0]  update_ROB_pos;
    logic [4:0]  update_rd;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_ROB_pos = '0;
    logic [31:0] cdb_val = '0;
    logic        cdb_mispredict = 1'b0;
    logic [31:0] cdb_target_pc = '0;
    logic [3:0]  query_pos1 = '0;
    logic [3:0]  query_pos2 = '0;
    logic        query_ready1, query_ready2;
    logic [31:0] query_val1, query_val2;
    logic        commit_valid;
    logic [3:0]  commit_ROB_pos;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        rob_clear;
    logic [31:0] clear_pc;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_SIZE(16), .POS_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .issue_ROB_pos(issue_ROB_pos), .rob_full(rob_full),
        .update_valid(update_valid), .update_ROB_pos(update_ROB_pos), .update_rd(update_rd),
        .cdb_valid(cdb_valid), .cdb_ROB_pos(cdb_ROB_pos), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
        .query_pos1(query_pos1), .query_pos2(query_pos2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_val1(query_val1), .query_val2(query_val2),
        .commit_valid(commit_valid), .commit_ROB_pos(commit_ROB_pos),
        .commit_rd(commit_rd), .commit_val(commit_val),
        .rob_clear(rob_clear), .clear_pc(clear_pc)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        done;
        logic [31:0] val;
        logic        br;
        logic        mp;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        int          stamp;
        logic [3:0]  pos;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        clr;
        logic [31:0] pc;
    } exp_t;

    ent_t mq[$];      // live instructions, oldest first
    int   m_head = 0; // position of the oldest instruction
    bit   m_clear = 0;
    exp_t sb[$];
    int   edges = 0;
    int   total = 0;
    int   bad = 0;

    logic        s_rst, s_rdy, s_iv, s_br, s_cv, s_mp;
    logic [4:0]  s_rd;
    logic [3:0]  s_cpos, s_q1, s_q2;
    logic [31:0] s_val, s_tgt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        s_rst = 0; s_rdy = 1; s_iv = 0; s_br = 0; s_rd = '0;
        s_cv = 0; s_mp = 0; s_cpos = '0; s_val = '0; s_tgt = '0;
        s_q1 = '0; s_q2 = '0;
    endtask

    task automatic qchk(string nm, logic [3:0] p, logic r, logic [31:0] v);
        int idx;
        idx = (int'(p) - m_head + 16) % 16;
        if (s_cv && s_cpos == p) begin
            chk({nm, "_ready"}, r, 1);
            chk({nm, "_val"}, v, s_val);
        end else if (idx < mq.size()) begin
            chk({nm, "_ready"}, r, mq[idx].done);
            if (mq[idx].done) chk({nm, "_val"}, v, mq[idx].val);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model
    task automatic step();
        bit   full_e, acc, com;
        int   idx;
        ent_t e;
        exp_t x;
        logic [3:0] tail_e;
        @(negedge clk);
        rst = s_rst; rdy = s_rdy;
        issue_valid = s_iv; issue_rd = s_rd; issue_is_branch = s_br;
        cdb_valid = s_cv; cdb_ROB_pos = s_cpos; cdb_val = s_val;
        cdb_mispredict = s_mp; cdb_target_pc = s_tgt;
        query_pos1 = s_q1; query_pos2 = s_q2;
        #1;
        full_e = (mq.size() == 16);
        tail_e = 4'((m_head + mq.size()) % 16);
        acc = s_iv && !full_e && s_rdy && !s_rst && !m_clear;
        chk("issue_pos", issue_ROB_pos, tail_e);
        chk("rob_full", rob_full, full_e);
        chk("update_valid", update_valid, acc);
        chk("update_pos", update_ROB_pos, tail_e);
        if (acc) chk("update_rd", update_rd, s_rd);
        qchk("q1", s_q1, query_ready1, query_val1);
        qchk("q2", s_q2, query_ready2, query_val2);

        if (s_rst) begin
            mq.delete(); m_head = 0; m_clear = 0;
        end else if (s_rdy) begin
            com = !m_clear && mq.size() > 0 && mq[0].done;
            if (com) begin
                x.stamp = edges + 1; x.pos = 4'(m_head); x.rd = mq[0].rd;
                x.val = mq[0].val; x.clr = mq[0].mp; x.pc = mq[0].tgt;
                sb.push_back(x);
            end
            if (com && mq[0].mp) begin
                mq.delete(); m_head = 0; m_clear = 1;
            end else begin
                if (s_cv && !m_clear) begin
                    idx = (int'(s_cpos) - m_head + 16) % 16;
                    if (idx < mq.size()) begin
                        e = mq[idx];
                        e.done = 1; e.val = s_val; e.mp = s_mp && e.br; e.tgt = s_tgt;
                        mq[idx] = e;
                    end
                end
                m_clear = 0;
                if (acc) begin
                    e.rd = s_rd; e.done = 0; e.val = '0; e.br = s_br; e.mp = 0; e.tgt = '0;
                    mq.push_back(e);
                end
                if (com) begin
                    void'(mq.pop_front());
                    m_head = (m_head + 1) % 16;
                end
            end
        end
    endtask

    // Monitor: compares every retire/flush strobe against the scoreboard
    initial begin
        logic mr, my, expc;
        exp_t it;
        forever begin
            @(posedge clk);
            mr = rst; my = rdy;
            edges++;
            #1;
            if (mr === 1'b1) begin
                chk("rst_commit_valid", commit_valid, 0);
                chk("rst_rob_clear", rob_clear, 0);
                chk("rst_commit_pos", commit_ROB_pos, 0);
                chk("rst_commit_rd", commit_rd, 0);
                chk("rst_commit_val", commit_val, 0);
                chk("rst_clear_pc", clear_pc, 0);
            end else if (my === 1'b1) begin
                while (sb.size() > 0 && sb[0].stamp < edges) begin
                    it = sb.pop_front();
                    chk("stale_commit", it.stamp, edges);
                end
                expc = (sb.size() > 0 && sb[0].stamp == edges);
                chk("commit_valid", commit_valid, expc);
                if (expc) begin
                    it = sb.pop_front();
                    chk("commit_pos", commit_ROB_pos, it.pos);
                    chk("commit_rd", commit_rd, it.rd);
                    chk("commit_val", commit_val, it.val);
                    chk("rob_clear", rob_clear, it.clr);
                    if (it.clr) chk("clear_pc", clear_pc, it.pc);
                end else begin
                    chk("rob_clear_idle", rob_clear, 0);
                end
            end
        end
    end

    task automatic do_reset();
        idle(); s_rst = 1; step(); idle();
    endtask

    task automatic issue(logic [4:0] rd, logic br);
        idle(); s_iv = 1; s_rd = rd; s_br = br; step(); idle();
    endtask

    task automatic cdb(logic [3:0] p, logic [31:0] v, logic mp, logic [31:0] t);
        idle(); s_cv = 1; s_cpos = p; s_val = v; s_mp = mp; s_tgt = t;
        s_q1 = p; s_q2 = p + 4'd1; step(); idle();
    endtask

    initial begin
        idle();
        s_rst = 1; step(); step(); idle();

        // Fill the buffer, then try one more issue
        for (int i = 0; i < 17; i++) issue(5'((i + 1) % 32), 1'b0);
        for (int i = 0; i < 2; i++) step();
        // Full buffer: head becomes ready while issue is pending
        idle(); s_cv = 1; s_cpos = 4'd0; s_val = 32'hAAAA_0000; s_iv = 1; s_rd = 5'd20; step();
        s_cv = 0; step(); step(); idle(); step();

        // Same-cycle forward then next-edge commit
        do_reset();
        issue(5'd5, 1'b0);
        cdb(4'd0, 32'h0000_1234, 1'b0, 32'h0);
        step(); step();

        // Out-of-order completion retires in order
        do_reset();
        for (int i = 0; i < 3; i++) issue(5'(i + 1), 1'b0);
        cdb(4'd2, 32'h22, 1'b0, 32'h0);
        cdb(4'd1, 32'h11, 1'b0, 32'h0);
        cdb(4'd0, 32'h00, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) step();

        // Mispredicted branch at pos3 flushes; stale CDB to pos4 afterwards
        do_reset();
        for (int i = 0; i < 6; i++) issue(5'(i + 8), i == 3);
        cdb(4'd3, 32'h3333, 1'b1, 32'h0000_0080);
        cdb(4'd4, 32'h4444, 1'b0, 32'h0);
        cdb(4'd0, 32'h1000, 1'b0, 32'h0);
        cdb(4'd1, 32'h1001, 1'b0, 32'h0);
        cdb(4'd2, 32'h1002, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cdb(4'd4, 32'h5555, 1'b0, 32'h0);
        issue(5'd9, 1'b0);
        for (int i = 0; i < 2; i++) step();

        // Freeze with a ready head
        do_reset();
        issue(5'd3, 1'b0);
        cdb(4'd0, 32'hBEEF, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle(); s_rdy = 0; s_iv = 1; s_rd = 5'd7; s_cv = 1; s_cpos = 4'd1; step();
        end
        idle(); step(); step(); step();

        // Randomized traffic with occasional freeze and reset
        for (int n = 0; n < 3000; n++) begin
            int k;
            idle();
            s_rst = ($urandom_range(0, 199) == 0);
            s_rdy = ($urandom_range(0, 9) != 0);
            s_iv  = ($urandom_range(0, 9) < 6);
            s_rd  = 5'($urandom);
            s_br  = ($urandom_range(0, 3) == 0);
            s_cv  = ($urandom_range(0, 1) == 1);
            s_val = $urandom;
            s_tgt = $urandom & 32'hFFFF_FFFC;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, mq.size() - 1);
                s_cpos = 4'((m_head + k) % 16);
                s_mp = mq[k].br && ($urandom_range(0, 3) == 0);
            end else begin
                s_cpos = 4'($urandom);
                s_mp = 0;
            end
            s_q1 = 4'($urandom);
            s_q2 = ($urandom_range(0, 1) == 1) ? s_cpos : 4'((m_head + $urandom_range(0, 3)) % 16);
            step();
        end

        idle();
        for (int i = 0; i < 4; i++) step();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
